// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - VGA raster counters, pipelined sync/blank outputs and frame strobe
// Counters advance every pixel clock; sync/blank are decoded from them and delayed SYNC_PIPE cycles.
module vga_sync_generator #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int SYNC_PIPE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       display_en,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (SYNC_PIPE < 0 || SYNC_PIPE > 3 || H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_param_check
    $error("vga_sync_generator: illegal parameter set");
  end

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       tick_q, tick_d;
  logic [2:0] decode;     // {vs_act, hs_act, de}
  logic [2:0] stage_out;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
    // Look ahead so the registered tick coincides with counters at (0, V_DISPLAY).
    tick_d = (h_d == '0) && (v_d == V_VIS);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_q    <= '0;
      v_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      tick_q <= tick_d;
    end
  end

  assign decode[0] = (h_q < H_VIS) && (v_q < V_VIS);
  assign decode[1] = (h_q >= HS_START) && (h_q < HS_END);
  assign decode[2] = (v_q >= VS_START) && (v_q < VS_END);

  if (SYNC_PIPE == 0) begin : g_nopipe
    assign stage_out = RST ? 3'b000 : decode;
  end else begin : g_pipe
    logic [2:0] pipe_q [SYNC_PIPE];

    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int i = 0; i < SYNC_PIPE; i++) pipe_q[i] <= 3'b000;
      end else begin
        pipe_q[0] <= decode;
        for (int i = 1; i < SYNC_PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign stage_out = pipe_q[SYNC_PIPE-1];
  end

  assign h_count    = h_q;
  assign v_count    = v_q;
  assign frame_tick = tick_q;
  assign display_en = stage_out[0];
  assign VGA_HS     = stage_out[1] ? SYNC_POL : ~SYNC_POL;
  assign VGA_VS     = stage_out[2] ? SYNC_POL : ~SYNC_POL;

endmodule
